// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared types, encodings and helper functions for the ID-stage branch hazard controller.
package branch_hazard_ctrl_pkg;

  localparam int unsigned DEF_REG_ADDR_W = 5;
  localparam int unsigned DEF_CNT_W      = 16;

  localparam logic [1:0] COND_JUMP = 2'd1;
  localparam logic [1:0] COND_BEQ  = 2'd2;
  localparam logic [1:0] COND_BNE  = 2'd3;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    RESOLVE = 2'd2
  } stateT;

  // Cycles one source must wait before its value reaches a forwarding point.
  function automatic logic [1:0] srcNeed(input logic exHit, input logic exLoad,
                                         input logic memHit, input logic memLoad);
    if (exHit) return exLoad ? 2'd2 : 2'd1;
    return (memHit && memLoad) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [1:0] maxNeed(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // MEM ALU result wins over WB; a load still in MEM is not forwardable.
  function automatic logic [1:0] fwdSel(input logic memHit, input logic memLoad,
                                        input logic wbHit);
    if (memHit && !memLoad) return FWD_MEM;
    if (wbHit) return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// Pipeline-side signal bundle of the branch hazard controller.
interface branch_hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_W = branch_hazard_ctrl_pkg::DEF_REG_ADDR_W,
  parameter int unsigned CNT_W      = branch_hazard_ctrl_pkg::DEF_CNT_W
);
  logic [1:0]            id_br_cmd;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic [REG_ADDR_W-1:0] ex_dest;
  logic                  ex_wb_en;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic                  mem_wb_en;
  logic                  mem_mem_read;
  logic [REG_ADDR_W-1:0] wb_dest;
  logic                  wb_wb_en;
  logic                  hold;
  logic                  br_cond;
  logic                  perf_clr;
  logic                  stall;
  logic                  br_taken;
  logic                  if_flush;
  logic [1:0]            fwd_sel1;
  logic [1:0]            fwd_sel2;
  logic [CNT_W-1:0]      perf_branches;
  logic [CNT_W-1:0]      perf_taken;
  logic [CNT_W-1:0]      perf_stalls;

  modport slave (
    input  id_br_cmd, id_src1, id_src2, ex_dest, ex_wb_en, ex_mem_read,
           mem_dest, mem_wb_en, mem_mem_read, wb_dest, wb_wb_en,
           hold, br_cond, perf_clr,
    output stall, br_taken, if_flush, fwd_sel1, fwd_sel2,
           perf_branches, perf_taken, perf_stalls
  );

  modport master (
    output id_br_cmd, id_src1, id_src2, ex_dest, ex_wb_en, ex_mem_read,
           mem_dest, mem_wb_en, mem_mem_read, wb_dest, wb_wb_en,
           hold, br_cond, perf_clr,
    input  stall, br_taken, if_flush, fwd_sel1, fwd_sel2,
           perf_branches, perf_taken, perf_stalls
  );
endinterface

// File: rtl/branch_hazard_ctrl_sat_counter.sv
// Saturating event counter with clear (beats increment) and freeze.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic             hold,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (!hold && inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch resolution: operand hazard stall, comparator forwarding,
// PC redirect / IF-ID flush qualification and branch performance counters.
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input logic                 clk,
  input logic                 rst,
  branch_hazard_ctrl_if.slave bus
);

  stateT      state;
  logic [1:0] cnt;
  logic       isJump;
  logic       isCond;
  logic       isBranch;
  logic       ex1, ex2, mem1, mem2, wb1, wb2;
  logic [1:0] need;
  logic       stallC;
  logic       resolve;
  logic       brTaken;

  function automatic logic stageMatch(input logic en,
                                      input logic [REG_ADDR_W-1:0] dest,
                                      input logic [REG_ADDR_W-1:0] src);
    return en && (dest == src) && (dest != '0);
  endfunction

  // Hazard detection and resolve qualification.
  always_comb begin
    isJump   = (bus.id_br_cmd == COND_JUMP);
    isCond   = (bus.id_br_cmd == COND_BEQ) || (bus.id_br_cmd == COND_BNE);
    isBranch = isJump || isCond;
    ex1      = stageMatch(bus.ex_wb_en,  bus.ex_dest,  bus.id_src1);
    ex2      = stageMatch(bus.ex_wb_en,  bus.ex_dest,  bus.id_src2);
    mem1     = stageMatch(bus.mem_wb_en, bus.mem_dest, bus.id_src1);
    mem2     = stageMatch(bus.mem_wb_en, bus.mem_dest, bus.id_src2);
    wb1      = stageMatch(bus.wb_wb_en,  bus.wb_dest,  bus.id_src1);
    wb2      = stageMatch(bus.wb_wb_en,  bus.wb_dest,  bus.id_src2);
    need     = 2'd0;
    if (isCond) begin
      need = maxNeed(srcNeed(ex1, bus.ex_mem_read, mem1, bus.mem_mem_read),
                     srcNeed(ex2, bus.ex_mem_read, mem2, bus.mem_mem_read));
    end
    stallC  = !rst && (((state == IDLE) && (need != 2'd0)) || (state == STALL));
    resolve = !rst && !bus.hold &&
              (((state == IDLE) && isBranch && (need == 2'd0)) || (state == RESOLVE));
    brTaken = resolve && (isJump || bus.br_cond);
  end

  // Stall sequencer; the ID instruction is frozen while we wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else if (!bus.hold) begin
      unique case (state)
        IDLE: begin
          if (need != 2'd0) begin
            cnt   <= need - 2'd1;
            state <= (need == 2'd2) ? STALL : RESOLVE;
          end
        end
        STALL: begin
          cnt   <= (cnt > 2'd1) ? cnt - 2'd1 : 2'd0;
          state <= (cnt > 2'd1) ? STALL : RESOLVE;
        end
        RESOLVE: begin
          cnt   <= 2'd0;
          state <= IDLE;
        end
        default: begin
          cnt   <= 2'd0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.stall    = stallC;
  assign bus.br_taken = brTaken;
  assign bus.if_flush = brTaken;
  assign bus.fwd_sel1 = rst ? FWD_REG : fwdSel(mem1, bus.mem_mem_read, wb1);
  assign bus.fwd_sel2 = rst ? FWD_REG : fwdSel(mem2, bus.mem_mem_read, wb2);

  sat_counter #(.CNT_W(CNT_W)) branchesCnt (
    .clk(clk), .rst(rst), .inc(resolve), .clr(bus.perf_clr), .hold(bus.hold),
    .count(bus.perf_branches)
  );

  sat_counter #(.CNT_W(CNT_W)) takenCnt (
    .clk(clk), .rst(rst), .inc(brTaken), .clr(bus.perf_clr), .hold(bus.hold),
    .count(bus.perf_taken)
  );

  sat_counter #(.CNT_W(CNT_W)) stallsCnt (
    .clk(clk), .rst(rst), .inc(stallC && !bus.hold), .clr(bus.perf_clr), .hold(bus.hold),
    .count(bus.perf_stalls)
  );

endmodule
